seven_segment_scan_controller: RTL and testbench
================================================

# seven_segment_scan_controller

Time-multiplexed scan controller that shares the stopwatch's single BCD-to-seven-segment encoder across NUM_DIGITS common-anode digits. Each frame it snapshots all digit values, then steps through the digits one at a time. For each digit it drives the BCD code to the encoder, waits a blanking interval to prevent ghosting, then enables that digit's anode. It sits between the stopwatch counter datapath and the encoder/anode pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is least significant.
- BLANK_CYCLES, 500, cycles per slot with all anodes off (≥1).
- SHOW_CYCLES, 49500, cycles per slot with the selected anode on (≥1).

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  scanning runs while high.
- zero_suppress  in  1  blank leading zeros when high.
- digits_bcd  in  4*NUM_DIGITS  digit k at bits [4k+3:4k].
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- bcd_out  out  4  code to the encoder.
- digit_en_n  out  NUM_DIGITS  anode enables, active-low.
- dp_out  out  1  decimal point for the selected digit, active-high.
- frame_tick  out  1  one-cycle pulse when a frame snapshot is taken.

## Operation
- States: IDLE, BLANK, SHOW. The registers are digit index `idx` (0..NUM_DIGITS-1), slot counter `cnt`, snapshot `snap_bcd`/`snap_dp`, and the output registers.
- IDLE: all outputs hold their reset values. When enable=1, go to BLANK with idx=0.
- Entry to BLANK with idx=0:
  - Load snap_bcd←digits_bcd and snap_dp←dp_in.
  - Register frame_tick=1 for exactly the first BLANK cycle.
  - Live inputs are ignored for the rest of the frame (no tearing).
- BLANK:
  - digit_en_n all 1; dp_out=0.
  - bcd_out = snap digit idx, loaded on BLANK entry and held through SHOW.
  - After BLANK_CYCLES cycles, go to SHOW.
- SHOW:
  - digit_en_n[idx]=0 unless digit idx is suppressed; all other anodes stay 1.
  - dp_out=snap_dp[idx].
  - After SHOW_CYCLES cycles, go to BLANK with idx+1. After idx=NUM_DIGITS-1, idx wraps to 0 and a new snapshot is taken.
- Digit idx is suppressed when either condition holds:
  - Its snapped value is >9. Invalid BCD is always blanked.
  - zero_suppress=1, idx≠0, and snap digits idx..NUM_DIGITS-1 are all 0.
- A suppressed digit still uses its full slot time, and dp_out is still driven, so the frame period is constant. Digit 0 is never zero-suppressed.
- enable=0 in any state: go to IDLE on the next edge, set outputs to reset values, and clear idx and cnt. Re-enable always starts a fresh frame at digit 0.
- zero_suppress is sampled live at each SHOW entry; it is not part of the snapshot.

## Timing
- Reset values: bcd_out=4'h0, digit_en_n=all 1, dp_out=0, frame_tick=0, state=IDLE, idx=0, cnt=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Slot length = BLANK_CYCLES+SHOW_CYCLES cycles. Frame length = NUM_DIGITS × slot length.
- First frame_tick occurs one cycle after the first edge that sees enable=1 in IDLE. frame_tick then repeats exactly every frame length while enable stays high.
- Anodes are never enabled in the cycle in which bcd_out changes. Between any two enabled digits there are ≥BLANK_CYCLES cycles with all anodes off.
- At most one digit_en_n bit is 0 in any cycle.
- Asserting rst_n low mid-slot forces the reset values immediately, with no wait for a clock edge.

## Structure
- Shared package/include (seg_pkg): state encodings (IDLE/BLANK/SHOW), BCD_BLANK threshold (9), default BLANK_CYCLES/SHOW_CYCLES.
- One sub-module, scan_slot_timer: the down-counter with load value and terminal-count strobe, used for both BLANK and SHOW durations.
- The encoder is instantiated at the top level, not inside this block.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, BLANK_CYCLES=2, SHOW_CYCLES=5 (slot 7 cycles, frame 28).
- Reset then enable=1, digits_bcd=16'h1234: frame_tick at 28-cycle spacing. Digit 0 shows bcd_out=4, digit_en_n=4'b1110 for 5 cycles after 2 blank cycles. Then 3/4'b1101, 2/4'b1011, 1/4'b0111.
- digits_bcd=16'h0070, zero_suppress=1: digits 3 and 2 are never enabled; digits 1 (7) and 0 (0) are shown. With zero_suppress=0, all four are enabled.
- digits_bcd changed mid-frame from 16'h1111 to 16'h2222: the remainder of the frame shows 1s, and the next frame shows 2s.
- digits_bcd=16'h00A5: digit 1 is never enabled; the frame period stays 28 cycles.
- dp_in=4'b0100: dp_out=1 only during SHOW of digit 2; dp_out=0 in all BLANK cycles.
- enable=0 mid-SHOW, and separately rst_n=0 mid-SHOW: all anodes go off (next edge for enable, immediately for reset). On re-enable, the next frame_tick is followed by digit 0 first.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the seven-segment scan controller:
//   - scan_state_t : FSM state encoding (IDLE / BLANK / SHOW)
//   - BCD_BLANK    : largest valid BCD code; anything above is blanked
//   - DEFAULT_*    : default slot timing for a 50 MHz-class clock
//   - bcd_invalid  : true when a nibble is not a decimal digit
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam logic [3:0] BCD_BLANK = 4'd9;

  localparam int DEFAULT_BLANK_CYCLES = 500;
  localparam int DEFAULT_SHOW_CYCLES  = 49500;

  function automatic logic bcd_invalid(input logic [3:0] v);
    return (v > BCD_BLANK);
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// scan_slot_timer
// Down-counter shared by the BLANK and SHOW phases of a scan slot.
// Loading value N-1 yields a phase of N cycles; tc is high while the
// count sits at zero, i.e. in the last cycle of the phase.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return to zero (used while scanning is off)
//   load       : load load_val (takes priority over counting)
//   load_val   : phase length minus one
//   tc         : terminal count (count == 0)
module scan_slot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller
// Time-multiplexes one BCD-to-seven-segment encoder across NUM_DIGITS
// common-anode digits. Each frame starts by snapshotting all digits and
// decimal points, then every digit gets a slot of BLANK_CYCLES with all
// anodes off (bcd_out already switched) followed by SHOW_CYCLES with its
// anode on. Suppressed digits keep their slot so the frame rate is fixed.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : scanning runs while high; low returns to IDLE
//   zero_suppress : blank leading zeros (sampled at each SHOW entry)
//   digits_bcd    : digit k at [4k+3:4k], digit 0 least significant
//   dp_in         : decimal point request per digit
//   bcd_out       : code to the encoder
//   digit_en_n    : anode enables, active-low, at most one low
//   dp_out        : decimal point for the selected digit
//   frame_tick    : one-cycle pulse in the first cycle of each frame
//   state_dbg     : current FSM state (scan_state_t encoding)
//
// Handshake: there is no valid/ready pair; frame_tick marks the cycle in
// which the snapshot of digits_bcd/dp_in has just been taken, and all
// outputs are registered.
module seven_segment_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  parameter int SHOW_CYCLES  = DEFAULT_SHOW_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    zero_suppress,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    dp_out,
  output logic                    frame_tick,
  output logic [1:0]              state_dbg
);

  localparam int MAX_CYC = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t state_r, state_nxt;
  logic [IDX_W-1:0] idx_r, idx_nxt, idx_inc;

  logic [3:0]            snap_bcd [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dp;
  logic                  snap_load;

  logic [3:0]            bcd_nxt;
  logic [NUM_DIGITS-1:0] en_nxt;
  logic                  dp_nxt;
  logic                  tick_nxt;

  logic                  tmr_clear, tmr_load, tmr_tc;
  logic [CNT_W-1:0]      tmr_val;

  logic                  upper_zero;
  logic                  suppress;
  logic [NUM_DIGITS-1:0] en_sel;

  scan_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  assign idx_inc = (idx_r == LAST_IDX) ? '0 : idx_r + 1'b1;
  assign en_sel  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r);

  // A digit is a leading zero when it and every more significant digit
  // of the snapshot are zero. Digit 0 is exempt so "0" still displays.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(idx_r)) && (snap_bcd[j] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    suppress = bcd_invalid(snap_bcd[idx_r]) ||
               (zero_suppress && (idx_r != '0) && upper_zero);
  end

  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    snap_load = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    bcd_nxt   = bcd_out;
    en_nxt    = '1;
    dp_nxt    = 1'b0;
    tick_nxt  = 1'b0;

    if (!enable) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
      tmr_clear = 1'b1;
      bcd_nxt   = 4'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt = ST_BLANK;
          idx_nxt   = '0;
          snap_load = 1'b1;
          tick_nxt  = 1'b1;
          bcd_nxt   = digits_bcd[3:0];
          tmr_load  = 1'b1;
          tmr_val   = BLANK_LOAD;
        end
        ST_BLANK: begin
          if (tmr_tc) begin
            state_nxt = ST_SHOW;
            tmr_load  = 1'b1;
            tmr_val   = SHOW_LOAD;
            en_nxt    = suppress ? '1 : en_sel;
            dp_nxt    = snap_dp[idx_r];
          end
        end
        ST_SHOW: begin
          if (tmr_tc) begin
            state_nxt = ST_BLANK;
            idx_nxt   = idx_inc;
            tmr_load  = 1'b1;
            tmr_val   = BLANK_LOAD;
            if (idx_r == LAST_IDX) begin
              // Wrap: the encoder gets digit 0 straight from the live
              // inputs, which is exactly what is being snapshotted.
              snap_load = 1'b1;
              tick_nxt  = 1'b1;
              bcd_nxt   = digits_bcd[3:0];
            end else begin
              bcd_nxt   = snap_bcd[idx_inc];
            end
          end else begin
            en_nxt = digit_en_n;
            dp_nxt = dp_out;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          tmr_clear = 1'b1;
          bcd_nxt   = 4'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      snap_dp    <= '0;
      bcd_out    <= 4'h0;
      digit_en_n <= '1;
      dp_out     <= 1'b0;
      frame_tick <= 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
        snap_bcd[j] <= 4'h0;
      end
    end else begin
      state_r    <= state_nxt;
      idx_r      <= idx_nxt;
      bcd_out    <= bcd_nxt;
      digit_en_n <= en_nxt;
      dp_out     <= dp_nxt;
      frame_tick <= tick_nxt;
      if (snap_load) begin
        snap_dp <= dp_in;
        for (int j = 0; j < NUM_DIGITS; j++) begin
          snap_bcd[j] <= digits_bcd[4*j +: 4];
        end
      end
    end
  end

  assign state_dbg = state_r;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
module tb_seven_segment_scan_controller;

  localparam int ND    = 4;
  localparam int SLOT  = 7;
  localparam int FRAME = 28;
  localparam int NF    = 10;
  localparam int W     = 9;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        zero_suppress;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en_n;
  logic        dp_out;
  logic        frame_tick;
  logic [1:0]  state_dbg;

  seven_segment_scan_controller #(
    .NUM_DIGITS   (ND),
    .BLANK_CYCLES (2),
    .SHOW_CYCLES  (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .zero_suppress (zero_suppress),
    .digits_bcd    (digits_bcd),
    .dp_in         (dp_in),
    .bcd_out       (bcd_out),
    .digit_en_n    (digit_en_n),
    .dp_out        (dp_out),
    .frame_tick    (frame_tick),
    .state_dbg     (state_dbg)
  );

  // Per-slot expectation: {bcd[3:0], digit_en_n during SHOW[3:0], dp during SHOW}
  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;
  int cyc;
  int last_tick_cyc;
  logic last_tick_valid;
  logic mon_busy;

  // Directed frames: inputs and the hand-computed set of shown digits.
  logic [15:0] t_bcd  [NF] = '{16'h1234, 16'h1234, 16'h0070, 16'h0070, 16'h1111,
                               16'h2222, 16'h00A5, 16'h00A5, 16'h0000, 16'h0900};
  logic [3:0]  t_dp   [NF] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001};
  logic        t_zs   [NF] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int          t_dly  [NF] = '{25, 25, 25, 25, 25, 10, 25, 25, 25, 25};
  logic [3:0]  t_mask [NF] = '{4'b1111, 4'b1111, 4'b0011, 4'b1111, 4'b1111,
                               4'b1111, 4'b1101, 4'b0001, 4'b0001, 4'b0111};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [15:0] bcd, input logic [3:0] dp, input logic [3:0] mask);
    logic [3:0] en;
    for (int s = 0; s < ND; s++) begin
      en = mask[s] ? ~(4'b0001 << s) : 4'hF;
      exp_q.push_back({bcd[4*s +: 4], en, dp[s]});
    end
  endtask

  task automatic wait_tick();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!frame_tick && i < 80);
    if (!frame_tick) begin
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: no frame_tick within 80 cycles");
    end
  endtask

  task automatic wait_mon_idle();
    int i;
    i = 0;
    while ((mon_busy || exp_q.size() != 0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (mon_busy || exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL mon_timeout: %0d slot entries still pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor: frame period ----------------
  initial begin
    last_tick_valid = 1'b0;
    last_tick_cyc   = 0;
    forever begin
      @(negedge clk);
      if (frame_tick) begin
        if (last_tick_valid) chk("frame_period", 16'(cyc - last_tick_cyc), 16'(FRAME));
        last_tick_cyc   = cyc;
        last_tick_valid = 1'b1;
      end
    end
  end

  // ---------------- monitor: scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    logic [9:0]   want;
    int p;
    mon_busy = 1'b0;
    e = '0;
    forever begin
      @(negedge clk);
      if (frame_tick && exp_q.size() >= ND) begin
        mon_busy = 1'b1;
        for (int o = 0; o < FRAME; o++) begin
          if (o != 0) @(negedge clk);
          p = o % SLOT;
          if (p == 0) e = exp_q.pop_front();
          want = {(o == 0), e[8:5], (p < 2) ? 4'hF : e[4:1], (p < 2) ? 1'b0 : e[0]};
          chk($sformatf("slot%0d_off%0d {tick,bcd,en_n,dp}", o / SLOT, p),
              16'({frame_tick, bcd_out, digit_en_n, dp_out}), 16'(want));
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    zero_suppress = 1'b0;
    digits_bcd = 16'h0;
    dp_in = 4'h0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 16'({frame_tick, bcd_out, digit_en_n, dp_out, state_dbg}), 16'({1'b0, 4'h0, 4'hF, 1'b0, 2'd0}));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold", 16'({frame_tick, bcd_out, digit_en_n, dp_out, state_dbg}), 16'({1'b0, 4'h0, 4'hF, 1'b0, 2'd0}));

    digits_bcd = t_bcd[0];
    dp_in = t_dp[0];
    zero_suppress = t_zs[0];
    push_frame(t_bcd[0], t_dp[0], t_mask[0]);
    enable = 1'b1;
    @(negedge clk);
    chk("first_tick_latency", 16'(frame_tick), 16'd1);

    for (int i = 1; i < NF; i++) begin
      if (i > 1) wait_tick();
      else begin
        repeat (t_dly[i]) @(negedge clk);
      end
      if (i > 1) repeat (t_dly[i]) @(negedge clk);
      digits_bcd = t_bcd[i];
      dp_in = t_dp[i];
      zero_suppress = t_zs[i];
      push_frame(t_bcd[i], t_dp[i], t_mask[i]);
    end

    // enable drop in the middle of digit 0's SHOW phase
    wait_mon_idle();
    wait_tick();
    repeat (4) @(negedge clk);
    chk("pre_disable_en", 16'(digit_en_n), 16'h000E);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_outputs", 16'({frame_tick, bcd_out, digit_en_n, dp_out, state_dbg}), 16'({1'b0, 4'h0, 4'hF, 1'b0, 2'd0}));
    last_tick_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("disable_hold", 16'({frame_tick, bcd_out, digit_en_n, dp_out, state_dbg}), 16'({1'b0, 4'h0, 4'hF, 1'b0, 2'd0}));

    digits_bcd = 16'h5678;
    dp_in = 4'b0001;
    zero_suppress = 1'b0;
    push_frame(16'h5678, 4'b0001, 4'b1111);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_tick", 16'(frame_tick), 16'd1);

    // asynchronous reset in the middle of digit 0's SHOW phase
    wait_mon_idle();
    wait_tick();
    repeat (4) @(negedge clk);
    chk("pre_reset_en", 16'(digit_en_n), 16'h000E);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 16'({frame_tick, bcd_out, digit_en_n, dp_out, state_dbg}), 16'({1'b0, 4'h0, 4'hF, 1'b0, 2'd0}));
    last_tick_valid = 1'b0;
    digits_bcd = 16'h8765;
    dp_in = 4'b1000;
    push_frame(16'h8765, 4'b1000, 4'b1111);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_tick", 16'(frame_tick), 16'd1);
    wait_mon_idle();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
